// File: rtl/mem_wb_pipe_pkg.sv
// Shared MEM/WB pipeline types: exception cause codes and the held entry record.
// The record is sized for the widest supported datapath; narrower instances zero-extend.
package mem_wb_pipe_pkg;

  localparam int unsigned PIPE_XLEN   = 32;
  localparam int unsigned PIPE_RIDX_W = 5;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_UPSTREAM = 2'b01,
    CAUSE_DTLB     = 2'b10
  } wb_cause_e;

  typedef struct packed {
    logic [PIPE_XLEN-1:0]   result;
    logic [PIPE_XLEN-1:0]   read_data;
    logic [PIPE_XLEN-1:0]   pc;
    logic [PIPE_XLEN-1:0]   faulty_address;
    logic [PIPE_RIDX_W-1:0] rd;
    logic                   mem_to_reg;
    logic                   reg_write;
    logic                   exception;
    logic                   iret;
    wb_cause_e              cause;
  } wb_entry_t;

  // Upstream exceptions are older than the DTLB fault, so they take priority.
  function automatic wb_cause_e resolve_cause(input logic up_exc, input logic dtlb_exc);
    if (up_exc) return CAUSE_UPSTREAM;
    if (dtlb_exc) return CAUSE_DTLB;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry FIFO between MEM capture and WB drain; ready is registered so
// upstream timing never depends on out_ready.
module wb_skid_buf
  import mem_wb_pipe_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  input  logic      flush,
  output logic      head_valid,
  output wb_entry_t head_entry,
  output logic      ready
);

  wb_entry_t  mem_q [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count_q;
  logic [1:0] count_nxt;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && (count_q != 2'd2);
  assign do_pop  = pop && (count_q != 2'd0);

  always_comb begin
    count_nxt = count_q;
    if (flush) begin
      count_nxt = 2'd0;
    end else if (do_push && !do_pop) begin
      count_nxt = count_q + 2'd1;
    end else if (do_pop && !do_push) begin
      count_nxt = count_q - 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      ready   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      ready   <= (count_nxt != 2'd2);
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= ~wr_ptr;
        if (do_pop) rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Payload storage needs no reset: head_valid gates every observable field.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_ptr] <= push_entry;
  end

  assign head_valid = (count_q != 2'd0);
  assign head_entry = mem_q[rd_ptr];

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: folds DTLB faults into the exception record and
// holds entries for writeback, either as one register stage or a two-entry skid buffer.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RIDX_W = 5,
  parameter int unsigned SKID   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_result,
  input  logic [XLEN-1:0]   in_read_data,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              in_exception,
  input  logic [XLEN-1:0]   in_faulty_address,
  input  logic              in_iret,
  input  logic              mem_enable,
  input  logic [XLEN-1:0]   mem_address,
  input  logic              dtlb_miss,
  input  logic              dtlb_ready,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [XLEN-1:0]   out_read_data,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_faulty_address,
  output logic [RIDX_W-1:0] out_rd,
  output logic              out_mem_to_reg,
  output logic              out_reg_write,
  output logic              out_exception,
  output logic              out_iret,
  output logic [1:0]        out_cause
);

  logic      dtlb_exc;
  logic      capture;
  logic      drain;
  logic      held_valid;
  wb_entry_t held_e;
  wb_entry_t new_e;

  assign dtlb_exc = dtlb_miss && dtlb_ready && mem_enable;
  assign capture  = in_valid && in_ready && !bubble && !flush;
  assign drain    = held_valid && out_ready;

  always_comb begin
    new_e                = '0;
    new_e.result         = PIPE_XLEN'(in_result);
    new_e.read_data      = PIPE_XLEN'(in_read_data);
    new_e.pc             = PIPE_XLEN'(in_pc);
    new_e.rd             = PIPE_RIDX_W'(in_rd);
    new_e.mem_to_reg     = in_mem_to_reg;
    new_e.iret           = in_iret;
    new_e.exception      = in_exception || dtlb_exc;
    new_e.reg_write      = in_reg_write && !(in_exception || dtlb_exc);
    new_e.cause          = resolve_cause(in_exception, dtlb_exc);
    case (new_e.cause)
      CAUSE_UPSTREAM: new_e.faulty_address = PIPE_XLEN'(in_faulty_address);
      CAUSE_DTLB:     new_e.faulty_address = PIPE_XLEN'(mem_address);
      default:        new_e.faulty_address = '0;
    endcase
  end

  generate
    if (SKID != 0) begin : g_skid
      wb_skid_buf u_skid_buf (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (capture),
        .push_entry (new_e),
        .pop        (drain),
        .flush      (flush),
        .head_valid (held_valid),
        .head_entry (held_e),
        .ready      (in_ready)
      );
    end else begin : g_reg
      // rdy_en keeps in_ready low through reset and for the edge it is released on.
      logic      rdy_en;
      logic      valid_q;
      wb_entry_t entry_q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          rdy_en  <= 1'b0;
          valid_q <= 1'b0;
          entry_q <= '0;
        end else begin
          rdy_en <= 1'b1;
          if (flush) begin
            valid_q <= 1'b0;
          end else if (capture) begin
            valid_q <= 1'b1;
            entry_q <= new_e;
          end else if (drain) begin
            valid_q <= 1'b0;
          end
        end
      end

      assign in_ready   = rdy_en && !bubble && !flush && (!valid_q || out_ready);
      assign held_valid = valid_q;
      assign held_e     = entry_q;
    end
  endgenerate

  assign out_valid          = held_valid;
  assign out_result         = held_valid ? held_e.result[XLEN-1:0]         : '0;
  assign out_read_data      = held_valid ? held_e.read_data[XLEN-1:0]      : '0;
  assign out_pc             = held_valid ? held_e.pc[XLEN-1:0]             : '0;
  assign out_faulty_address = held_valid ? held_e.faulty_address[XLEN-1:0] : '0;
  assign out_rd             = held_valid ? held_e.rd[RIDX_W-1:0]           : '0;
  assign out_mem_to_reg     = held_valid && held_e.mem_to_reg;
  assign out_reg_write      = held_valid && held_e.reg_write;
  assign out_exception      = held_valid && held_e.exception;
  assign out_iret           = held_valid && held_e.iret;
  assign out_cause          = held_valid ? held_e.cause : CAUSE_NONE;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: skid-buffer instance plus a single-stage instance on shared inputs.
module tb_mem_wb_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_mem_to_reg, in_reg_write, in_exception, in_iret;
  logic [31:0] in_result, in_read_data, in_pc, in_faulty_address, mem_address;
  logic [4:0]  in_rd;
  logic        mem_enable, dtlb_miss, dtlb_ready, bubble, flush, out_ready;

  logic        in_ready, out_valid, out_mem_to_reg, out_reg_write, out_exception, out_iret;
  logic [31:0] out_result, out_read_data, out_pc, out_faulty_address;
  logic [4:0]  out_rd;
  logic [1:0]  out_cause;

  logic        d0_in_ready, d0_out_valid, d0_out_mem_to_reg, d0_out_reg_write, d0_out_exception, d0_out_iret;
  logic [31:0] d0_out_result, d0_out_read_data, d0_out_pc, d0_out_faulty_address;
  logic [4:0]  d0_out_rd;
  logic [1:0]  d0_out_cause;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_wb_pipe #(.XLEN(32), .RIDX_W(5), .SKID(1)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_read_data(in_read_data), .in_rd(in_rd),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_pc(in_pc),
    .in_exception(in_exception), .in_faulty_address(in_faulty_address), .in_iret(in_iret),
    .mem_enable(mem_enable), .mem_address(mem_address), .dtlb_miss(dtlb_miss),
    .dtlb_ready(dtlb_ready), .bubble(bubble), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_read_data(out_read_data),
    .out_pc(out_pc), .out_faulty_address(out_faulty_address), .out_rd(out_rd),
    .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
    .out_exception(out_exception), .out_iret(out_iret), .out_cause(out_cause)
  );

  mem_wb_pipe #(.XLEN(32), .RIDX_W(5), .SKID(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(d0_in_ready),
    .in_result(in_result), .in_read_data(in_read_data), .in_rd(in_rd),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_pc(in_pc),
    .in_exception(in_exception), .in_faulty_address(in_faulty_address), .in_iret(in_iret),
    .mem_enable(mem_enable), .mem_address(mem_address), .dtlb_miss(dtlb_miss),
    .dtlb_ready(dtlb_ready), .bubble(bubble), .flush(flush), .out_valid(d0_out_valid),
    .out_ready(out_ready), .out_result(d0_out_result), .out_read_data(d0_out_read_data),
    .out_pc(d0_out_pc), .out_faulty_address(d0_out_faulty_address), .out_rd(d0_out_rd),
    .out_mem_to_reg(d0_out_mem_to_reg), .out_reg_write(d0_out_reg_write),
    .out_exception(d0_out_exception), .out_iret(d0_out_iret), .out_cause(d0_out_cause)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_result = 0; in_read_data = 0; in_rd = 0; in_mem_to_reg = 0;
    in_reg_write = 0; in_pc = 0; in_exception = 0; in_faulty_address = 0; in_iret = 0;
    mem_enable = 0; mem_address = 0; dtlb_miss = 0; dtlb_ready = 0;
    bubble = 0; flush = 0; out_ready = 0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] rdat,
                       input logic [4:0] rd, input logic rw, input logic m2r, input logic exc,
                       input logic [31:0] fa, input logic iret, input logic men,
                       input logic [31:0] maddr, input logic miss, input logic drdy);
    in_valid = 1; in_pc = pc; in_result = res; in_read_data = rdat; in_rd = rd;
    in_reg_write = rw; in_mem_to_reg = m2r; in_exception = exc; in_faulty_address = fa;
    in_iret = iret; mem_enable = men; mem_address = maddr; dtlb_miss = miss; dtlb_ready = drdy;
  endtask

  task automatic test_reset();
    reset_n = 0;
    clear_inputs();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_result !== 32'h0 || out_cause !== 2'b00) begin bad++; $display("FAIL reset_fields got=%h/%b exp=0/00", out_result, out_cause); end
    total++; if (d0_in_ready !== 1'b0) begin bad++; $display("FAIL reset_d0_in_ready got=%b exp=0", d0_in_ready); end
    step(); step();
    reset_n = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_in_ready_pre_edge got=%b exp=0", in_ready); end
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    total++; if (d0_in_ready !== 1'b1) begin bad++; $display("FAIL release_d0_in_ready got=%b exp=1", d0_in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1;
    offer(32'h100, 32'h5, 32'h0, 5'd3, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_result !== 32'h5) begin bad++; $display("FAIL basic_capture got=%b/%h exp=1/00000005", out_valid, out_result); end
    total++; if (out_pc !== 32'h100 || out_rd !== 5'd3 || out_reg_write !== 1'b1) begin bad++; $display("FAIL basic_fields got pc=%h rd=%0d rw=%b exp pc=100 rd=3 rw=1", out_pc, out_rd, out_reg_write); end
    total++; if (out_cause !== 2'b00 || out_exception !== 1'b0 || out_faulty_address !== 32'h0) begin bad++; $display("FAIL basic_no_exc got=%b/%b/%h exp=00/0/0", out_cause, out_exception, out_faulty_address); end
    step();
    total++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_pc !== 32'h0) begin bad++; $display("FAIL basic_drain_zero got=%b/%h/%h exp=0/0/0", out_valid, out_result, out_pc); end
  endtask

  task automatic test_dtlb();
    out_ready = 1;
    offer(32'h104, 32'h77, 32'h0, 5'd4, 1, 0, 0, 32'h99, 0, 1, 32'h2000, 1, 1);
    step();
    offer(32'h108, 32'h88, 32'h0, 5'd5, 1, 0, 0, 32'h99, 0, 1, 32'h3000, 1, 0);
    total++; if (out_exception !== 1'b1 || out_cause !== 2'b10) begin bad++; $display("FAIL dtlb_exc got=%b/%b exp=1/10", out_exception, out_cause); end
    total++; if (out_faulty_address !== 32'h2000 || out_reg_write !== 1'b0) begin bad++; $display("FAIL dtlb_fault got=%h/%b exp=00002000/0", out_faulty_address, out_reg_write); end
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_result !== 32'h88) begin bad++; $display("FAIL dtlb_not_ready_entry got=%b/%h exp=1/00000088", out_valid, out_result); end
    total++; if (out_exception !== 1'b0 || out_cause !== 2'b00 || out_faulty_address !== 32'h0 || out_reg_write !== 1'b1) begin bad++; $display("FAIL dtlb_not_ready_flags got=%b/%b/%h/%b exp=0/00/0/1", out_exception, out_cause, out_faulty_address, out_reg_write); end
    step();
  endtask

  task automatic test_priority();
    out_ready = 1;
    offer(32'h10C, 32'h1, 32'hDEAD, 5'd6, 1, 1, 1, 32'h44, 1, 1, 32'h2000, 1, 1);
    step();
    in_valid = 0;
    total++; if (out_cause !== 2'b01 || out_faulty_address !== 32'h44) begin bad++; $display("FAIL prio_cause got=%b/%h exp=01/00000044", out_cause, out_faulty_address); end
    total++; if (out_exception !== 1'b1 || out_reg_write !== 1'b0) begin bad++; $display("FAIL prio_flags got=%b/%b exp=1/0", out_exception, out_reg_write); end
    total++; if (out_read_data !== 32'hDEAD || out_mem_to_reg !== 1'b1 || out_iret !== 1'b1 || out_rd !== 5'd6) begin bad++; $display("FAIL prio_passthru got=%h/%b/%b/%0d exp=0000dead/1/1/6", out_read_data, out_mem_to_reg, out_iret, out_rd); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    offer(32'h200, 32'hA, 32'h0, 5'd1, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_occ1 got=%b exp=1", in_ready); end
    offer(32'h204, 32'hB, 32'h0, 5'd2, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    step();
    total++; if (in_ready !== 1'b0 || out_result !== 32'hA) begin bad++; $display("FAIL b2b_full got=%b/%h exp=0/0000000a", in_ready, out_result); end
    offer(32'h208, 32'hC, 32'h0, 5'd3, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    step();
    total++; if (in_ready !== 1'b0 || out_result !== 32'hA || out_pc !== 32'h200) begin bad++; $display("FAIL b2b_hold got=%b/%h/%h exp=0/0000000a/00000200", in_ready, out_result, out_pc); end
    out_ready = 1;
    step();
    total++; if (out_valid !== 1'b1 || out_result !== 32'hB) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/0000000b", out_valid, out_result); end
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_result !== 32'hC) begin bad++; $display("FAIL b2b_third got=%b/%h exp=1/0000000c", out_valid, out_result); end
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b/%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    offer(32'h300, 32'hD, 32'h0, 5'd1, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    step();
    offer(32'h304, 32'hE, 32'h0, 5'd2, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    step();
    total++; if (in_ready !== 1'b0 || out_result !== 32'hD) begin bad++; $display("FAIL flush_prefill got=%b/%h exp=0/0000000d", in_ready, out_result); end
    offer(32'h308, 32'hF, 32'h0, 5'd3, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    flush = 1;
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0) begin bad++; $display("FAIL flush_empty got=%b/%b/%h exp=0/1/0", out_valid, in_ready, out_result); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_overrides_capture got=%b exp=0", out_valid); end
    flush = 0;
    in_valid = 0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_late_capture got=%b exp=0", out_valid); end
  endtask

  task automatic test_bubble();
    out_ready = 0;
    offer(32'h400, 32'h11, 32'h0, 5'd1, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    step();
    total++; if (out_valid !== 1'b1 || out_result !== 32'h11) begin bad++; $display("FAIL bubble_prefill got=%b/%h exp=1/00000011", out_valid, out_result); end
    offer(32'h404, 32'h22, 32'h0, 5'd2, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    bubble = 1;
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bubble_ready_indep got=%b exp=1", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bubble_drain_no_capture got=%b exp=0", out_valid); end
    bubble = 0;
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_result !== 32'h22) begin bad++; $display("FAIL bubble_release_capture got=%b/%h exp=1/00000022", out_valid, out_result); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bubble_final_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    offer(32'h500, 32'h33, 32'h0, 5'd1, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_prefill got=%b exp=1", out_valid); end
    offer(32'h504, 32'h44, 32'h0, 5'd2, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    #2;
    reset_n = 0;
    #1;
    total++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_pc !== 32'h0 || out_cause !== 2'b00) begin bad++; $display("FAIL rmid_async_clear got=%b/%h/%h/%b exp=0/0/0/00", out_valid, out_result, out_pc, out_cause); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready_low got=%b exp=0", in_ready); end
    step();
    reset_n = 1;
    step();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rmid_release got=%b/%b exp=1/0", in_ready, out_valid); end
    in_valid = 0;
    step();
  endtask

  task automatic test_single_stage();
    clear_inputs();
    step();
    offer(32'h600, 32'h55, 32'h0, 5'd1, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    #1;
    total++; if (d0_in_ready !== 1'b1) begin bad++; $display("FAIL s0_ready_empty got=%b exp=1", d0_in_ready); end
    step();
    total++; if (d0_out_valid !== 1'b1 || d0_out_result !== 32'h55 || d0_in_ready !== 1'b0) begin bad++; $display("FAIL s0_capture got=%b/%h/%b exp=1/00000055/0", d0_out_valid, d0_out_result, d0_in_ready); end
    offer(32'h604, 32'h66, 32'h0, 5'd2, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    out_ready = 1;
    #1;
    total++; if (d0_in_ready !== 1'b1) begin bad++; $display("FAIL s0_ready_comb got=%b exp=1", d0_in_ready); end
    bubble = 1;
    #1;
    total++; if (d0_in_ready !== 1'b0) begin bad++; $display("FAIL s0_ready_bubble got=%b exp=0", d0_in_ready); end
    bubble = 0;
    flush = 1;
    #1;
    total++; if (d0_in_ready !== 1'b0) begin bad++; $display("FAIL s0_ready_flush got=%b exp=0", d0_in_ready); end
    flush = 0;
    step();
    in_valid = 0;
    total++; if (d0_out_valid !== 1'b1 || d0_out_result !== 32'h66) begin bad++; $display("FAIL s0_replace got=%b/%h exp=1/00000066", d0_out_valid, d0_out_result); end
    step();
    total++; if (d0_out_valid !== 1'b0 || d0_out_result !== 32'h0) begin bad++; $display("FAIL s0_drain got=%b/%h exp=0/0", d0_out_valid, d0_out_result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dtlb();
    test_priority();
    test_back_to_back();
    test_flush();
    test_bubble();
    test_reset_mid();
    test_single_stage();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
